// File: rtl/hi_fsk_ssp_sched.sv
// HF FSK symbol packer, byte FIFO and SSP serializer toward the ARM.
// Packs 2-bit symbols four to a byte and streams framed words back-to-back.
module hi_fsk_ssp_sched #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  IDLE_BYTE  = 8'h00
) (
  input  logic                          ck_1356meg,
  input  logic                          rst_n,
  input  logic                          sym_valid,
  input  logic [7:0]                    sym_code,
  input  logic                          sym_flush,
  input  logic                          clr_ovf,
  input  logic [3:0]                    minor_mode,
  output logic                          ssp_clk,
  output logic                          ssp_frame,
  output logic                          ssp_din,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf_sticky
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  function automatic logic [1:0] sym_map(input logic [7:0] code);
    case (code)
      8'd0:    sym_map = 2'b00;
      8'd28:   sym_map = 2'b10;
      8'd32:   sym_map = 2'b11;
      default: sym_map = 2'b01;
    endcase
  endfunction

  logic [7:0]    pack_q, pack_d, pbyte_q, pbyte_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [2:0]    nsym;
  logic          push_q, push_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          ovf_q, ovf_d, pop, push_ok, ovf_set;
  state_t        state_q, state_d;
  logic [1:0]    hsel_q, mode_sel;
  logic [3:0]    half, ph_last, ph_pre, ph_q, ph_d;
  logic          clk_q, clk_d, fall;
  logic [7:0]    shreg_q;
  logic [2:0]    bitcnt_q;

  // Packer: absorb the symbol first, then complete or flush the byte
  always_comb begin
    pack_d  = pack_q;
    pbyte_d = pbyte_q;
    cnt_d   = cnt_q;
    push_d  = 1'b0;
    nsym    = {1'b0, cnt_q};
    if (sym_valid) begin
      pack_d = {pack_q[5:0], sym_map(sym_code)};
      nsym   = nsym + 3'd1;
    end
    if (nsym == 3'd4) begin
      push_d  = 1'b1;
      pbyte_d = pack_d;
      cnt_d   = 2'd0;
    end else if (sym_flush && nsym != 3'd0) begin
      push_d = 1'b1;
      cnt_d  = 2'd0;
      case (nsym)
        3'd1:    pbyte_d = {pack_d[1:0], 6'b0};
        3'd2:    pbyte_d = {pack_d[3:0], 4'b0};
        default: pbyte_d = {pack_d[5:0], 2'b0};
      endcase
    end else begin
      cnt_d = nsym[1:0];
    end
  end

  always_ff @(posedge ck_1356meg) begin
    pack_q  <= pack_d;
    pbyte_q <= pbyte_d;
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      push_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      push_q <= push_d;
    end
  end

  // FIFO: a pop in the same cycle frees room for a push into a full FIFO
  assign pop     = (state_q == S_LOAD) && (lvl_q != '0);
  assign push_ok = push_q && ((lvl_q != FULL) || pop);
  assign ovf_set = push_q && !push_ok;

  always_comb begin
    lvl_d = lvl_q;
    if (push_ok && !pop)      lvl_d = lvl_q + LW'(1);
    else if (!push_ok && pop) lvl_d = lvl_q - LW'(1);
    ovf_d = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge ck_1356meg) begin
    if (push_ok) mem[wptr_q] <= pbyte_q;
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lvl_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop)     rptr_q <= rptr_q + AW'(1);
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
    end
  end

  // Prescaler: ph counts one bit period, ssp_clk is high in its upper half
  assign mode_sel = (minor_mode > 4'd3) ? 2'd3 : minor_mode[1:0];
  assign half     = 4'd1 << hsel_q;
  assign ph_last  = {half[2:0], 1'b0} - 4'd1;
  assign ph_pre   = ph_last - 4'd1;
  assign fall     = (ph_q == ph_last);
  assign ph_d     = fall ? 4'd0 : ph_q + 4'd1;
  assign clk_d    = (ph_d >= half);

  always_ff @(posedge ck_1356meg) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // LOAD always lands on the falling-edge cycle, so it is entered one clock early
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ph_q == ph_pre) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (bitcnt_q == 3'd0 && ph_q == ph_pre) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ssp_clk    = clk_q;
    ssp_din    = shreg_q[7];
    ssp_frame  = (state_q == S_SHIFT) && (bitcnt_q == 3'd7);
    fifo_level = lvl_q;
    ovf_sticky = ovf_q;
  end

  always_ff @(posedge ck_1356meg) begin
    if (!rst_n) begin
      ph_q     <= 4'd0;
      clk_q    <= 1'b0;
      hsel_q   <= 2'd0;
      shreg_q  <= 8'd0;
      bitcnt_q <= 3'd0;
    end else begin
      ph_q  <= ph_d;
      clk_q <= clk_d;
      if (state_q == S_LOAD) begin
        hsel_q   <= mode_sel;
        shreg_q  <= pop ? mem[rptr_q] : IDLE_BYTE;
        bitcnt_q <= 3'd7;
      end else if (state_q == S_SHIFT && fall && bitcnt_q != 3'd0) begin
        shreg_q  <= {shreg_q[6:0], 1'b0};
        bitcnt_q <= bitcnt_q - 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_hi_fsk_ssp_sched.sv
// Bench for hi_fsk_ssp_sched: directed and random symbol traffic against a
// timeline model of the framed SSP byte stream.
module tb_hi_fsk_ssp_sched;
  localparam int DEPTH = 8;
  localparam logic [7:0] IDLE = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n, sym_valid, sym_flush, clr_ovf;
  logic [7:0] sym_code;
  logic [3:0] minor_mode;
  logic       ssp_clk, ssp_frame, ssp_din, ovf_sticky;
  logic [3:0] fifo_level;

  always #5 clk = ~clk;

  hi_fsk_ssp_sched #(.FIFO_DEPTH(DEPTH), .IDLE_BYTE(IDLE)) dut (
    .ck_1356meg(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_code(sym_code),
    .sym_flush(sym_flush), .clr_ovf(clr_ovf), .minor_mode(minor_mode),
    .ssp_clk(ssp_clk), .ssp_frame(ssp_frame), .ssp_din(ssp_din),
    .fifo_level(fifo_level), .ovf_sticky(ovf_sticky)
  );

  int vec = 0;
  int miss = 0;

  // Model state: queued bytes, collected symbols, byte awaiting FIFO entry,
  // and the current word's start time, byte and half period.
  logic [7:0] fq[$];
  logic [1:0] syms[$];
  bit         pend = 0;
  logic [7:0] pend_b = 8'h00;
  logic       m_ovf = 1'b0;
  int         n = 0, cur_ws = 0, next_ws = 2, cur_h = 1;
  logic [7:0] cur_byte = 8'h00;

  function automatic logic [1:0] mapc(input logic [7:0] c);
    if (c == 8'd0)  return 2'b00;
    if (c == 8'd28) return 2'b10;
    if (c == 8'd32) return 2'b11;
    return 2'b01;
  endfunction

  function automatic logic [7:0] rcode();
    case ($urandom_range(0, 3))
      0: return 8'd0;
      1: return 8'd28;
      2: return 8'd32;
      default: return 8'($urandom_range(1, 255));
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s t=%0t observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic step();
    bit   set;
    int   pos, b, m;
    logic e_clk, e_din, e_frm;
    @(posedge clk);
    #1;
    set = 0;
    if (!rst_n) begin
      fq.delete();
      syms.delete();
      pend = 0;
      m_ovf = 1'b0;
      n = 0;
      next_ws = 2;
    end else begin
      n++;
      if (n == next_ws) begin
        cur_byte = (fq.size() > 0) ? fq.pop_front() : IDLE;
        m = (minor_mode > 4'd3) ? 3 : int'(minor_mode);
        cur_h = 1 << m;
        cur_ws = n;
        next_ws = n + 16 * cur_h;
      end
      if (pend) begin
        if (fq.size() < DEPTH) fq.push_back(pend_b);
        else set = 1;
      end
      if (set) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      pend = 0;
      if (sym_valid) syms.push_back(mapc(sym_code));
      if (syms.size() == 4 || (sym_flush && syms.size() > 0)) begin
        pend = 1;
        pend_b = 8'h00;
        for (int i = 0; i < 4; i++)
          pend_b = {pend_b[5:0], (i < syms.size()) ? syms[i] : 2'b00};
        syms.delete();
      end
    end
    if (!rst_n || n == 0) begin
      e_clk = 1'b0; e_din = 1'b0; e_frm = 1'b0;
    end else if (n == 1) begin
      e_clk = 1'b1; e_din = 1'b0; e_frm = 1'b0;
    end else begin
      pos = n - cur_ws;
      b = pos / (2 * cur_h);
      e_clk = ((pos % (2 * cur_h)) >= cur_h);
      e_din = cur_byte[7 - b];
      e_frm = (b == 0);
    end
    chk("ssp_clk", 32'(ssp_clk), 32'(e_clk));
    chk("ssp_din", 32'(ssp_din), 32'(e_din));
    chk("ssp_frame", 32'(ssp_frame), 32'(e_frm));
    chk("fifo_level", 32'(fifo_level), 32'(fq.size()));
    chk("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
    sym_valid = 1'b0;
    sym_flush = 1'b0;
    clr_ovf   = 1'b0;
  endtask

  initial begin
    logic [7:0] t1 [4];
    t1[0] = 8'd28; t1[1] = 8'd32; t1[2] = 8'd0; t1[3] = 8'd28;
    rst_n = 1'b0; sym_valid = 1'b0; sym_flush = 1'b0; clr_ovf = 1'b0;
    sym_code = 8'd0; minor_mode = 4'd0;
    repeat (3) step();
    rst_n = 1'b1;

    // Byte 0xB2 built from four spaced strobes at the fastest rate
    for (int i = 0; i < 4; i++) begin
      sym_valid = 1'b1; sym_code = t1[i];
      step();
      repeat (31) step();
    end
    repeat (64) step();

    // Idle fill words at H = 4
    minor_mode = 4'd2;
    repeat (3 * 64 + 80) step();

    // Burst of 40 symbols at H = 8 overflows the FIFO, then drain and clear
    minor_mode = 4'd3;
    for (int i = 0; i < 40; i++) begin
      sym_valid = 1'b1; sym_code = rcode();
      step();
    end
    repeat (128 * 11) step();
    clr_ovf = 1'b1;
    step();
    repeat (20) step();

    // Partial byte flush, then a flush with nothing pending
    minor_mode = 4'd0;
    repeat (150) step();
    sym_valid = 1'b1; sym_code = 8'd32; step();
    sym_valid = 1'b1; sym_code = 8'd5;  step();
    sym_flush = 1'b1; step();
    repeat (5) step();
    sym_flush = 1'b1; step();
    sym_valid = 1'b1; sym_code = 8'd28; sym_flush = 1'b1; step();
    repeat (60) step();

    // Rate change mid-word
    repeat (7) step();
    minor_mode = 4'd3;
    repeat (300) step();

    // Random traffic, rates and controls
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0)
        minor_mode = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 15))
                                                 : 4'($urandom_range(0, 1));
      sym_valid = ($urandom_range(0, 2) == 0);
      sym_code  = rcode();
      sym_flush = ($urandom_range(0, 15) == 0);
      clr_ovf   = ($urandom_range(0, 63) == 0);
      step();
    end

    // Reset mid-word with bytes queued, then restart
    minor_mode = 4'd1;
    clr_ovf = 1'b1;
    step();
    repeat (300) step();
    for (int i = 0; i < 12; i++) begin
      sym_valid = 1'b1; sym_code = rcode();
      step();
    end
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (100) step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/hi_fsk_ssp_sched.md
Name: hi_fsk_ssp_sched

Overview:
- Sits between the HF FSK subcarrier classifier and the SSP link to the ARM.
- Converts the classifier's per-window divider codes (0 / 28 / 32) into 2-bit symbols and packs four symbols into each byte.
- Buffers the bytes in a small FIFO and schedules their serial transmission at an ARM-selected SSP bit rate.
- Inserts fill bytes when no data is pending and flags overruns, so the ARM sees a continuous, framed byte stream.

Parameters:
- FIFO_DEPTH, 8, byte FIFO entries; power of 2, range 2..32.
- IDLE_BYTE, 8'h00, byte sent when the FIFO is empty at a word boundary.

Ports:
- ck_1356meg  input  1  13.56 MHz clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- sym_valid  input  1  one-cycle strobe: classifier window result valid.
- sym_code  input  8  classifier divider code: 0, 28, 32; other values are invalid.
- sym_flush  input  1  one-cycle strobe: pad the partial byte and push it.
- clr_ovf  input  1  clears ovf_sticky.
- minor_mode  input  4  SSP rate select: 0 = half-period 1 clk; 1 = 2; 2 = 4; 3 = 8; others behave as 3.
- ssp_clk  output  1  SSP bit clock.
- ssp_frame  output  1  high during bit 7 (first bit) of each word.
- ssp_din  output  1  serial data, MSB first.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- ovf_sticky  output  1  set when a packed byte is dropped.

Behaviour:
- Reset (rst_n low at a posedge): ssp_clk = 0, ssp_frame = 0, ssp_din = 0, fifo_level = 0, ovf_sticky = 0, packer count = 0, prescaler = 0, state = IDLE. Reset applied mid-word aborts the word and drops the FIFO contents.
- Symbol map: 0 -> 2'b00; 28 -> 2'b10; 32 -> 2'b11; any other code -> 2'b01.
- Packer:
  - On sym_valid, shift the symbol into pack[7:0] from the LSB end (first symbol ends in bits 7:6) and increment the 2-bit count.
  - When the 4th symbol arrives, push the byte in that same cycle (push strobe registered, latency 1 clk) and reset the count to 0.
- Flush:
  - sym_flush with count > 0: left-justify the pending symbols, pad with 00, push, reset the count.
  - sym_flush with count = 0: no-op.
  - sym_valid and sym_flush in the same cycle: absorb the symbol first, then flush. A flush after the 4th symbol is then a no-op.
- FIFO:
  - Push when not full, or when a pop occurs in the same cycle.
  - Push when full with no pop: byte dropped, ovf_sticky <= 1.
  - Set has priority over clr_ovf in the same cycle.
  - fifo_level is exact after every cycle, including simultaneous push and pop.
- Prescaler / ssp_clk:
  - Half-period H is latched from minor_mode only in state LOAD.
  - ssp_clk toggles every H clocks. A bit period is 2H clocks: low half, then high half.
  - ssp_din and ssp_frame change only on the clock where ssp_clk goes 1 -> 0, so the ARM samples on the rising edge.
- FSM:
  - IDLE: leave on the first ssp_clk falling-edge slot after reset; go to LOAD.
  - LOAD (1 clk):
    - Latch H.
    - If the FIFO is non-empty, pop and load shreg; otherwise load shreg = IDLE_BYTE.
    - Set bitcnt = 7 and go to SHIFT.
  - SHIFT:
    - Present shreg[7]; ssp_frame = 1 while bitcnt = 7.
    - At each bit-period end, shift left and decrement bitcnt.
    - After bit 0, enter LOAD such that the next word's bit 7 follows with no gap.
- Word period is exactly 16H clocks; words are back-to-back indefinitely.
- A minor_mode change mid-word takes effect at the next word boundary.

Test Plan:
- minor_mode = 0, codes 28, 32, 0, 28 on four strobes 32 clks apart -> byte 8'hB2 serialized MSB first; frame coincides with the first bit; 16-clk words.
- No input for 3 words, minor_mode = 2 -> three 8'h00 words, each 64 clks; ssp_frame pulse width 8 clks.
- 40 symbols at 1 per clk, minor_mode = 3, FIFO_DEPTH = 8 -> fifo_level saturates at 8, ovf_sticky = 1, later output bytes are in order with drops only. clr_ovf then clears it.
- Codes 32 then 5, then sym_flush -> pushed byte 8'hD0; flush with count = 0 pushes nothing.
- minor_mode switched 0 -> 3 mid-word -> current word finishes at 16 clks; next word takes 128 clks.
- rst_n low mid-SHIFT with 3 bytes queued -> all outputs 0 and fifo_level = 0 on the next clk; restart sends IDLE_BYTE.
